// File: rtl/riscbee_pkg.sv
// riscbee_pkg: shared ALU op encodings and datapath defaults
package riscbee_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_RIDX = 5;
  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SLL  = 3'b001,
    SLT  = 3'b010,
    SLTU = 3'b011,
    XOR  = 3'b100,
    SRL  = 3'b101,
    OR   = 3'b110,
    AND  = 3'b111
  } alu_op_e;
  // switch turns ADD into SUB and SRL into SRA
  localparam logic SW_SUB = 1'b1;
  localparam logic SW_SRA = 1'b1;
endpackage

// File: rtl/operand_bypass.sv
// operand_bypass: resolves one source operand through MEM/WB forwarding and flags load-use
module operand_bypass #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic [RIDX-1:0] rs,
  input  logic [XLEN-1:0] val,
  input  logic            used,
  input  logic            mem_we,
  input  logic            mem_load,
  input  logic [RIDX-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_we,
  input  logic [RIDX-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] fwd,
  output logic            hazard
);
  logic mem_hit, wb_hit;
  always_comb begin
    mem_hit = mem_we && mem_rd == rs && rs != '0;
    wb_hit  = wb_we && wb_rd == rs && rs != '0;
    fwd     = (mem_hit && !mem_load) ? mem_data : wb_hit ? wb_data : val;
    hazard  = used && mem_hit && mem_load;
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: single-entry ID/EX register feeding the ALU with forwarded operands
module alu_issue_stage
  import riscbee_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int RIDX = DEF_RIDX
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RIDX-1:0] in_rs1,
  input  logic [RIDX-1:0] in_rs2,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [2:0]      in_op,
  input  logic            in_switch,
  input  logic [RIDX-1:0] in_rd,
  input  logic            in_we,
  input  logic            mem_we,
  input  logic [RIDX-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            mem_load,
  input  logic            wb_we,
  input  logic [RIDX-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  output logic            alu_switch,
  output logic [RIDX-1:0] out_rd,
  output logic            out_we
);
  logic            valid_q, use_imm_q, switch_q, we_q;
  logic [RIDX-1:0] rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0] rs1_val_q, rs2_val_q, imm_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] fwd1, fwd2;
  logic            haz1, haz2, fire, load;
  logic            ld_hit1, ld_hit2, hold_hit1, hold_hit2;

  operand_bypass #(.XLEN(XLEN), .RIDX(RIDX)) u_bp1 (
    .rs(rs1_q), .val(rs1_val_q), .used(1'b1),
    .mem_we(mem_we), .mem_load(mem_load), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd(fwd1), .hazard(haz1)
  );

  operand_bypass #(.XLEN(XLEN), .RIDX(RIDX)) u_bp2 (
    .rs(rs2_q), .val(rs2_val_q), .used(!use_imm_q),
    .mem_we(mem_we), .mem_load(mem_load), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd(fwd2), .hazard(haz2)
  );

  always_comb begin
    out_valid  = valid_q && !haz1 && !haz2;
    fire       = out_valid && out_ready;
    in_ready   = !valid_q || fire;
    load       = in_valid && in_ready && !flush;
    ld_hit1    = wb_we && wb_rd == in_rs1 && in_rs1 != '0;
    ld_hit2    = wb_we && wb_rd == in_rs2 && in_rs2 != '0;
    hold_hit1  = wb_we && wb_rd == rs1_q && rs1_q != '0;
    hold_hit2  = wb_we && wb_rd == rs2_q && rs2_q != '0;
    alu_a      = fwd1;
    alu_b      = use_imm_q ? imm_q : fwd2;
    alu_op     = op_q;
    alu_switch = switch_q;
    out_rd     = rd_q;
    out_we     = we_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      use_imm_q <= 1'b0;
      switch_q  <= 1'b0;
      we_q      <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
      op_q      <= '0;
    end else begin
      valid_q <= flush ? 1'b0 : load ? 1'b1 : fire ? 1'b0 : valid_q;
      if (load) begin
        use_imm_q <= in_use_imm;
        switch_q  <= in_switch;
        we_q      <= in_we;
        rs1_q     <= in_rs1;
        rs2_q     <= in_rs2;
        rd_q      <= in_rd;
        rs1_val_q <= ld_hit1 ? wb_data : in_rs1_val;
        rs2_val_q <= ld_hit2 ? wb_data : in_rs2_val;
        imm_q     <= in_imm;
        op_q      <= in_op;
      end else if (valid_q && !fire) begin
        // a held entry must not miss register writes that retire while it waits
        if (hold_hit1) rs1_val_q <= wb_data;
        if (hold_hit2) rs2_val_q <= wb_data;
      end
    end
  end
endmodule
